// File: rtl/rd_burst_ctrl_pkg.sv
// Shared widths, burst/response encodings and FSM state type for the
// AXI-style read burst controller.
package rd_burst_ctrl_pkg;

  localparam int ADD_WIDTH    = 32;
  localparam int ADD_ID_WIDTH = 4;
  localparam int BURST_LEN    = 4;
  localparam int BURST_SIZE   = 3;
  localparam int BURST_TYPE   = 2;
  localparam int DATA_WIDTH   = 32;

  localparam logic [BURST_TYPE-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_TYPE-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_TYPE-1:0] BURST_WRAP  = 2'b10;
  localparam logic [BURST_TYPE-1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Largest legal size: one beat may not exceed the data bus width.
  localparam logic [BURST_SIZE-1:0] MAX_SIZE = BURST_SIZE'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_SEND    = 2'd3
  } state_e;

  // log2(len+1) for legal WRAP lengths; 0 marks an illegal wrap length.
  function automatic logic [2:0] wrap_log2(input logic [BURST_LEN-1:0] len);
    logic [2:0] r;
    case (len)
      4'd1:    r = 3'd1;
      4'd3:    r = 3'd2;
      4'd7:    r = 3'd3;
      4'd15:   r = 3'd4;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rd_burst_ctrl_burst_addr_gen.sv
// Combinational next-beat address generator with protocol error detection.
module burst_addr_gen
  import rd_burst_ctrl_pkg::*;
(
  input  logic [ADD_WIDTH-1:0]  addr,
  input  logic [BURST_SIZE-1:0] size,
  input  logic [BURST_LEN-1:0]  len,
  input  logic [BURST_TYPE-1:0] burst,
  output logic [ADD_WIDTH-1:0]  next_addr,
  output logic                  err
);

  localparam logic [ADD_WIDTH-1:0] ONE = {{(ADD_WIDTH-1){1'b0}}, 1'b1};

  logic [ADD_WIDTH-1:0] bytes_d;
  logic [ADD_WIDTH-1:0] incr_d;
  logic [ADD_WIDTH-1:0] mask_d;
  logic [2:0]           wlog_d;

  always_comb begin
    bytes_d = ONE << size;
    incr_d  = addr + bytes_d;
    wlog_d  = wrap_log2(len);
    // Window is bytes*(len+1); len+1 is a power of two for legal wraps.
    mask_d  = (bytes_d << wlog_d) - ONE;
    err     = (burst == BURST_RSVD) ||
              ((burst == BURST_WRAP) && (wlog_d == 3'd0)) ||
              (size > MAX_SIZE);
    if (err) begin
      next_addr = incr_d;
    end else begin
      case (burst)
        BURST_FIXED: next_addr = addr;
        BURST_WRAP:  next_addr = (addr & ~mask_d) | (incr_d & mask_d);
        default:     next_addr = incr_d;
      endcase
    end
  end

endmodule

// File: rtl/rd_burst_ctrl.sv
// Read burst controller: accepts one burst request, reads each beat from a
// one-cycle-latency memory and returns it on an AXI-style R channel.
module rd_burst_ctrl
  import rd_burst_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mod2_valid_in,
  output logic                    mod2_ready_out,
  input  logic [ADD_WIDTH-1:0]    address_in,
  input  logic [ADD_ID_WIDTH-1:0] id_in,
  input  logic [BURST_LEN-1:0]    len_in,
  input  logic [BURST_SIZE-1:0]   size_in,
  input  logic [BURST_TYPE-1:0]   burst_in,
  output logic                    mem_rd_en,
  output logic [ADD_WIDTH-1:0]    mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [ADD_ID_WIDTH-1:0] rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  state_e                  state_q;
  logic [ADD_WIDTH-1:0]    addr_q;
  logic [BURST_LEN-1:0]    len_q;
  logic [BURST_SIZE-1:0]   size_q;
  logic [BURST_TYPE-1:0]   burst_q;
  logic [BURST_LEN-1:0]    beat_q;
  logic                    mem_rd_en_q;
  logic [ADD_WIDTH-1:0]    mem_addr_q;
  logic [ADD_ID_WIDTH-1:0] rid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;
  logic                    rlast_q;
  logic                    rvalid_q;
  logic [ADD_WIDTH-1:0]    next_addr_d;
  logic                    err_d;

  burst_addr_gen u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr_d),
    .err       (err_d)
  );

  // Ready is gated by reset so it reads 0 in reset and 1 the cycle it releases.
  assign mod2_ready_out = (state_q == S_IDLE) && !reset;
  assign mem_rd_en      = mem_rd_en_q;
  assign mem_addr       = mem_addr_q;
  assign rid            = rid_q;
  assign rdata          = rdata_q;
  assign rresp          = rresp_q;
  assign rlast          = rlast_q;
  assign rvalid         = rvalid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rid_q       <= '0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      rlast_q     <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mod2_valid_in) begin
            addr_q      <= address_in;
            len_q       <= len_in;
            size_q      <= size_in;
            burst_q     <= burst_in;
            rid_q       <= id_in;
            beat_q      <= '0;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= address_in;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_rd_en_q <= 1'b0;
          state_q     <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rdata_q  <= mem_rdata;
          rresp_q  <= err_d ? RESP_SLVERR : RESP_OKAY;
          rlast_q  <= (beat_q == len_q);
          rvalid_q <= 1'b1;
          state_q  <= S_SEND;
        end
        S_SEND: begin
          if (rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (beat_q == len_q) begin
              state_q <= S_IDLE;
            end else begin
              beat_q      <= beat_q + 4'd1;
              addr_q      <= next_addr_d;
              mem_addr_q  <= next_addr_d;
              mem_rd_en_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rd_burst_ctrl.md
RD_BURST_CTRL -- requirements
Module: rd_burst_ctrl

Interface
REQ-001 SHALL use shared params: ADD_WIDTH, 32, byte address width; ADD_ID_WIDTH, 4, ID width; BURST_LEN, 4, len width.
REQ-002 SHALL use shared params: BURST_SIZE, 3, size width; BURST_TYPE, 2, burst width; DATA_WIDTH, 32, data width.
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-004 SHALL have reset  in  1  synchronous, active-high.
REQ-005 SHALL have mod2_valid_in  in  1  address stage holds a request.
REQ-006 SHALL have mod2_ready_out  out  1  controller can accept a request.
REQ-007 SHALL have address_in  in  ADD_WIDTH  start byte address; id_in  in  ADD_ID_WIDTH  transaction ID.
REQ-008 SHALL have len_in  in  BURST_LEN  beats-1; size_in  in  BURST_SIZE  log2 bytes/beat; burst_in  in  BURST_TYPE  burst type.
REQ-009 SHALL have mem_rd_en  out  1  memory read strobe; mem_addr  out  ADD_WIDTH  memory byte address.
REQ-010 SHALL have mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en.
REQ-011 SHALL have rid  out  ADD_ID_WIDTH; rdata  out  DATA_WIDTH; rresp  out  2; rlast  out  1.
REQ-012 SHALL have rvalid  out  1; rready  in  1  AXI read-data handshake.

Function
REQ-013 SHALL implement FSM IDLE, ISSUE, CAPTURE, SEND.
REQ-014 IDLE: mod2_ready_out=1; on mod2_valid_in=1 latch address/id/len/size/burst, clear beat count, go ISSUE.
REQ-015 mod2_ready_out SHALL be 0 in every state other than IDLE.
REQ-016 ISSUE: mem_rd_en=1 for exactly one cycle with mem_addr=current beat address; go CAPTURE.
REQ-017 CAPTURE: register mem_rdata into rdata; go SEND.
REQ-018 SEND: rvalid=1; rid, rdata, rresp, rlast SHALL stay stable until rready=1.
REQ-019 SEND with rready=1 and beat count==len: go IDLE; otherwise increment beat count, update address, go ISSUE.
REQ-020 rlast SHALL be 1 only while rvalid=1 on the beat with beat count==len.
REQ-021 Latency SHALL be: accept at cycle N gives first rvalid at N+3; each beat costs 3 cycles plus rready stall cycles.
REQ-022 Beat bytes SHALL be 1<<size.
REQ-023 FIXED (2'b00) SHALL keep the address unchanged.
REQ-024 INCR (2'b01) SHALL add beat bytes, modulo 2^ADD_WIDTH.
REQ-025 WRAP (2'b10) SHALL add beat bytes within a window of bytes*(len+1), aligned to that size: the low log2(window) bits wrap, the upper bits hold.
REQ-026 rresp SHALL be 2'b00 (OKAY) except in the SLVERR cases below.
REQ-027 Burst 2'b11, WRAP with len not in {1,3,7,15}, or (1<<size) > DATA_WIDTH/8 SHALL give rresp=2'b10 (SLVERR) on every beat, with addresses stepped as INCR; beats are still read and returned.
REQ-028 mem_rd_en SHALL be 0 in IDLE, CAPTURE and SEND, including while stalled on rready.

Reset
REQ-029 While reset=1, the following SHALL hold on the next clk edge and stay until reset=0: state=IDLE, mod2_ready_out=0, rvalid=0, rlast=0, mem_rd_en=0, rdata=0, rid=0, rresp=0, mem_addr=0, beat count=0.
REQ-030 Reset mid-burst SHALL abandon the burst; no further beats or mem_rd_en are issued.
REQ-031 mod2_ready_out SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 Widths, burst encodings (FIXED/INCR/WRAP) and resp codes (OKAY/SLVERR) SHALL live in the shared param file.
REQ-033 Next-address computation SHALL be one combinational sub-module, burst_addr_gen (in: addr, size, len, burst; out: next_addr, err).

Verification
REQ-034 INCR len=3 size=2 addr=0x100 -> mem_addr 0x100,0x104,0x108,0x10C; rlast on beat 4 only; rresp=0.
REQ-035 WRAP len=3 size=2 addr=0x108 -> mem_addr 0x108,0x10C,0x100,0x104; rresp=0.
REQ-036 FIXED len=2 addr=0x40, id=5 -> three beats, each mem_addr=0x40, rid=5; first rvalid 3 cycles after accept.
REQ-037 INCR len=1 with rready=0 for 5 cycles on beat 1 -> rvalid/rdata/rlast stable, no mem_rd_en during the stall, beat 2 follows.
REQ-038 Reset held 1 cycle after beat 1 of a len=3 burst -> rvalid=0 next edge, no further mem_rd_en, mod2_ready_out=1 after release.
REQ-039 burst=2'b11 len=1 addr=0x20 -> 2 beats at 0x20,0x24, both rresp=2'b10.
